// File: rtl/frame_scan_pkg.sv
// Shared types and sizing helpers for the raster-order frame scan controller.
package frame_scan_pkg;

  localparam int PIX_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SCAN  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             eof;
  } pix_beat_t;

  // One slot per read in flight plus two so a returning beat never has to wait
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/frame_scan_ctrl_fifo.sv
// Skid FIFO holding returned pixel beats until the downstream stage accepts them.
module scan_skid_fifo
  import frame_scan_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pix_beat_t     wdata,
  input  logic          pop,
  output pix_beat_t     rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  pix_beat_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster-order BRAM frame reader with credit-limited issue and a skid FIFO on the stream side.
// Optional border drop for the Gabor stage: define FRAME_SCAN_BORDER_SKIP_EN.
module frame_scan_ctrl
  import frame_scan_pkg::*;
#(
  parameter int IMG_W       = 516,
  parameter int IMG_H       = 516,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = PIX_W,
  parameter int RD_LAT      = 2,
  parameter int KERNEL_SIZE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CW    = cnt_width(DEPTH);
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
`ifdef FRAME_SCAN_BORDER_SKIP_EN
  localparam bit SKIP  = 1'b1;
`else
  localparam bit SKIP  = 1'b0;
`endif
  localparam int B     = SKIP ? KERNEL_SIZE / 2 : 0;

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_HI   = XW'(IMG_W - 1 - B);
  localparam logic [YW-1:0] ROW_HI   = YW'(IMG_H - 1 - B);

  state_t            state;
  logic [XW-1:0]     col;
  logic [YW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     inflight, fifo_count;
  logic              fifo_empty, issue, ret, push, pop, last_rd, eol_rd, eof_rd, drain_done;
  logic [RD_LAT:1]   vld_pipe, eol_pipe, eof_pipe;
  pix_beat_t         wbeat, head;

  assign eol_rd  = (col == COL_HI);
  assign eof_rd  = eol_rd && (row == ROW_HI);
  assign last_rd = (col == COL_LAST) && (row == ROW_LAST);
  assign issue   = (state == SCAN) &&
                   (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
  assign ret     = vld_pipe[RD_LAT];
  assign pop     = pix_valid && pix_ready;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign bram_en   = issue;
  assign bram_addr = addr;

  // Sideband rides with the read so it lines up with bram_rdata at pipe exit
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      eol_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      eol_pipe[1] <= issue && eol_rd;
      eof_pipe[1] <= issue && eof_rd;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        eol_pipe[i] <= eol_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
    end
  end

`ifdef FRAME_SCAN_BORDER_SKIP_EN
  localparam logic [XW-1:0] COL_LO = XW'(B);
  localparam logic [YW-1:0] ROW_LO = YW'(B);

  logic            keep_rd, eof_seen;
  logic [RD_LAT:1] keep_pipe;

  assign keep_rd = (col >= COL_LO) && (col <= COL_HI) && (row >= ROW_LO) && (row <= ROW_HI);
  assign push    = ret && keep_pipe[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      keep_pipe <= '0;
    end else begin
      keep_pipe[1] <= issue && keep_rd;
      for (int i = 2; i <= RD_LAT; i++) keep_pipe[i] <= keep_pipe[i-1];
    end
  end

  // Border reads after the eof pixel are still in flight; wait until they have all landed
  always_ff @(posedge clk) begin
    if (rst)                          eof_seen <= 1'b0;
    else if (state == IDLE && start)  eof_seen <= 1'b0;
    else if (pop && head.eof)         eof_seen <= 1'b1;
  end

  assign drain_done = eof_seen && (inflight == '0) && fifo_empty;
`else
  assign push       = ret;
  assign drain_done = pop && head.eof;
`endif

  assign wbeat = '{data: bram_rdata, eol: eol_pipe[RD_LAT], eof: eof_pipe[RD_LAT]};

  scan_skid_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wbeat),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? head.data : '0;
  assign pix_eol   = pix_valid && head.eol;
  assign pix_eof   = pix_valid && head.eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(ret);
      case (state)
        IDLE: if (start) begin
          col   <= '0;
          row   <= '0;
          addr  <= '0;
          state <= SCAN;
        end
        SCAN: if (issue) begin
          if (last_rd) begin
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN:   if (drain_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_scan_ctrl.md
Name: frame_scan_ctrl

Overview:
- Sequences raster-order reads of one image frame out of the single-port pixel BRAM.
- Emits the returned pixels as a valid/ready stream tagged with end-of-line and end-of-frame, feeding the Gabor window/line-buffer stage.
- Absorbs the fixed BRAM read latency using credit-based issue and a small skid FIFO, so downstream backpressure never loses data.
- Started by the frame-level sequencer with start/busy/done.

Parameters:
- IMG_W, 516, pixels per row
- IMG_H, 516, rows per frame (IMG_W*IMG_H = 266256)
- ADDR_W, 19, BRAM address width
- DATA_W, 8, pixel width
- RD_LAT, 2, BRAM cycles from en/addr to rdata valid (1..4)
- KERNEL_SIZE, 5, Gabor kernel size; only used by the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the last pixel has been accepted downstream
- bram_en  out  1  read enable
- bram_addr  out  ADDR_W  read address
- bram_rdata  in  DATA_W  read data, valid RD_LAT cycles after bram_en
- pix_data  out  DATA_W  stream pixel
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready
- pix_eol  out  1  pixel is the last of its row
- pix_eof  out  1  pixel is the last of the frame

Behaviour:
- Reset: state=IDLE. busy, done, bram_en, pix_valid, pix_eol, pix_eof are 0. bram_addr and all counters are 0. FIFO empty, in-flight count 0.
- FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 clears the col, row and addr counters, then moves to SCAN.
  - start is ignored in every other state.
- SCAN: issue one read per cycle when inflight + fifo_count < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2.
  - bram_en=1 with bram_addr = row*IMG_W + col.
  - The address is a running incrementer, not a multiplier. The bench checks it against the formula.
  - col wraps from IMG_W-1 to 0 and row increments on that wrap.
  - Issuing the read at (IMG_H-1, IMG_W-1) moves to DRAIN. No read is issued in DRAIN.
- Sideband: eol = (col==IMG_W-1); eof = eol && (row==IMG_H-1).
  - Both travel in an RD_LAT-deep valid/eol/eof shift pipe alongside the read.
  - At pipe exit, rdata, eol and eof are written into the FIFO together.
- Stream output:
  - pix_valid = FIFO non-empty; pix_data, pix_eol and pix_eof come from the FIFO head.
  - Pop on pix_valid && pix_ready.
  - Output must hold stable while valid && !ready.
  - The FIFO never overflows by construction. An assertion checks this.
- Simultaneous issue, return and pop in one cycle: in-flight and FIFO counts update by net change.
- DRAIN -> DONE when the eof pixel is popped. DONE asserts done=1 for exactly one cycle, then returns to IDLE.
- busy=1 in SCAN, DRAIN and DONE.
- Latency:
  - The first bram_en occurs the cycle after start is accepted.
  - The first pix_valid occurs RD_LAT+1 cycles after the first bram_en when ready is held high.
- Throughput: 1 pixel/cycle sustained with ready held high. Frame length is IMG_W*IMG_H cycles plus RD_LAT+2 cycles of overhead.
- Reset mid-frame: everything returns to reset values on the next edge. In-flight returns are discarded via the cleared shift pipe.

Optional Feature:
- FRAME_SCAN_BORDER_SKIP_EN.
- Defined:
  - Reads still cover the whole frame, because the line buffers need every pixel.
  - Pixels within B = KERNEL_SIZE/2 (integer division) of any edge are dropped at FIFO write.
  - pix_eol marks column IMG_W-1-B; pix_eof marks (IMG_H-1-B, IMG_W-1-B).
  - The stream carries (IMG_W-2B)*(IMG_H-2B) pixels.
  - DRAIN ends when in-flight reaches 0 and the FIFO is empty, after the eof pop.
- Undefined: the full frame is streamed as described above.

Decomposition:
- Package frame_scan_pkg holds:
  - state enum state_t (IDLE, SCAN, DRAIN, DONE)
  - localparam functions for FIFO_DEPTH and the count width
  - a packed struct pix_beat_t {data, eol, eof}
- Sub-module scan_skid_fifo: synchronous FIFO of pix_beat_t, parameter DEPTH, with push/pop/count/empty and the same clk/rst.

Test Plan:
- Use IMG_W=4, IMG_H=3, RD_LAT=2, with BRAM model rdata = addr[7:0].
1. Ready always high, start pulse -> 12 beats with data 0..11 on consecutive cycles; eol on 3, 7, 11; eof on 11 only; done pulses once, 1 cycle after the beat-11 handshake; busy drops with done.
2. Ready low for 10 cycles mid-frame -> no more than 4 reads outstanding+buffered; no lost or duplicated beat; data held stable while stalled; sequence still 0..11.
3. Random ready at 30% duty over 3 back-to-back frames -> each frame yields 0..11 in order; start while busy is ignored (beat count stays 12 per frame).
4. rst asserted at beat 5 with reads in flight -> outputs return to 0 next cycle; a new start yields a clean 0..11 with no stale data.
5. RD_LAT=4, IMG_W=516, IMG_H=516 -> bram_addr equals row*516+col for all 266256 reads; last address is 266255.
6. With FRAME_SCAN_BORDER_SKIP_EN, IMG_W=8, IMG_H=6, KERNEL_SIZE=5 -> 8 beats with data 18, 19, 20, 21, 26, 27, 28, 29; eol on 21 and 29; eof on 29.
